// File: rtl/spi_peripheral.sv
// SPI peripheral (mode 0, CPOL=0 / CPHA=0, MSB first) running entirely in the
// clk domain. sclk, cs_n and mosi are oversampled through flop synchronisers,
// and every action is driven by edges of the synchronised copies.
//
// Ports
//   clk, rst_n   system clock / asynchronous active-low reset
//   sclk, cs_n   SPI clock and chip select from the controller (async)
//   mosi         serial data in, MSB first
//   miso         serial data out, MSB first; forced low when miso_oe=0
//   miso_oe      output enable, high while a frame is active
//   tx_data      byte to transmit
//   tx_load      write tx_data into the transmit buffer (accepted if tx_ready)
//   tx_ready     transmit buffer empty
//   rx_data      last complete received byte
//   rx_valid     one-clk pulse when rx_data is updated
//   tx_underrun  one-clk pulse when a byte starts with an empty buffer
//   busy         frame active
module spi_peripheral #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, flush;
  logic                   s_sclk, s_cs_n, s_mosi;
  logic                   prev_sclk, prev_cs_n, armed;

  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf;
  logic              buf_full, reload_pend;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic frame_start, frame_end, rise_act, fall_act, transfer, load_ok, last_bit;

  assign s_sclk = sclk_sync[SYNC_STAGES-1];
  assign s_cs_n = cs_sync[SYNC_STAGES-1];
  assign s_mosi = mosi_sync[SYNC_STAGES-1];

  // Synchronisers, plus a flush marker that tells when the synchroniser output
  // reflects real pin samples rather than reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      flush     <= '0;
      prev_sclk <= 1'b0;
      prev_cs_n <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      prev_sclk <= s_sclk;
      prev_cs_n <= s_cs_n;
      // A frame may only start after cs_n has genuinely been seen high; this
      // stops a cs_n held low through reset from looking like a fresh fall.
      armed     <= armed | (flush[SYNC_STAGES-1] & s_cs_n);
    end
  end

  assign sclk_rise = s_sclk & ~prev_sclk;
  assign sclk_fall = ~s_sclk & prev_sclk;
  assign cs_rise   = s_cs_n & ~prev_cs_n;
  assign cs_fall   = ~s_cs_n & prev_cs_n & armed;

  assign frame_start = (state_q == IDLE) & cs_fall;
  assign frame_end   = (state_q == ACTIVE) & cs_rise;
  // A deselect takes priority over any sclk edge seen in the same cycle.
  assign rise_act    = (state_q == ACTIVE) & ~cs_rise & sclk_rise;
  assign fall_act    = (state_q == ACTIVE) & ~cs_rise & sclk_fall;
  assign last_bit    = rise_act & (bit_cnt == 3'd7);
  assign transfer    = frame_start | (fall_act & reload_pend);
  assign load_ok     = tx_load & ~buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      reload_pend <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= last_bit;
      tx_underrun <= 1'b0;

      if (frame_start || frame_end) bit_cnt <= '0;
      else if (rise_act)            bit_cnt <= bit_cnt + 3'd1;

      if (rise_act) rx_shift <= {rx_shift[DATA_W-2:0], s_mosi};
      if (last_bit) rx_data  <= {rx_shift[DATA_W-2:0], s_mosi};

      // The fall after the 8th rise starts the next byte: reload, don't shift.
      if (frame_start || frame_end) reload_pend <= 1'b0;
      else if (last_bit)            reload_pend <= 1'b1;
      else if (fall_act)            reload_pend <= 1'b0;

      if (load_ok) tx_buf <= tx_data;

      // An empty buffer at transfer time still accepts a same-cycle tx_load.
      if (transfer) begin
        tx_shift    <= buf_full ? tx_buf : '0;
        tx_underrun <= ~buf_full;
        buf_full    <= load_ok;
      end else begin
        if (fall_act) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        buf_full <= buf_full | load_ok;
      end
    end
  end

  assign miso_oe  = (state_q == ACTIVE);
  assign busy     = (state_q == ACTIVE);
  assign miso     = miso_oe & tx_shift[DATA_W-1];
  assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: drives mode-0 SPI frames with sclk half
// periods of HALF clk cycles and checks serial data, pulses and flags.
module tb_spi_peripheral;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_data;

  int         checks = 0;
  int         errors = 0;
  int         rxv_cnt = 0;
  int         unr_cnt = 0;
  logic [7:0] rx_seen = 8'h00;

  spi_peripheral #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt = rxv_cnt + 1;
      rx_seen = rx_data;
    end
    if (tx_underrun) unr_cnt = unr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    clks(1);
    tx_load = 1'b0;
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    clks(HALF);
  endtask

  // Frames end with sclk high so the final byte has no trailing fall in-frame.
  task automatic frame_end();
    cs_n = 1'b1;
    clks(HALF);
    sclk = 1'b0;
    clks(HALF);
  endtask

  // Shift n bits of mo (MSB first); mi collects miso sampled before each rise.
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    int lat;
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0;
      mosi = mo[i];
      clks(HALF);
      mi[i] = miso;
      sclk = 1'b1;
      if (i == 0) begin
        lat = 0;
        for (int k = 1; k <= HALF; k++) begin
          clks(1);
          if (rx_valid && lat == 0) lat = k;
        end
        check("rx_valid_latency", 32'(lat >= 1 && lat <= 4), 1);
      end else begin
        clks(HALF);
      end
    end
  endtask

  initial begin
    logic [7:0] mi;
    int r0, u0;

    // Reset state
    clks(3);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    clks(10);

    // One-byte frame
    load(8'hA5);
    check("s1_tx_ready_full", tx_ready, 0);
    r0 = rxv_cnt; u0 = unr_cnt;
    frame_start();
    check("s1_busy", busy, 1);
    check("s1_miso_oe", miso_oe, 1);
    check("s1_tx_ready_after_xfer", tx_ready, 1);
    spi_bits(8'h3C, 8, mi);
    check("s1_miso_bits", mi, 8'hA5);
    frame_end();
    check("s1_rx_data", rx_data, 8'h3C);
    check("s1_rx_valid_cnt", rxv_cnt - r0, 1);
    check("s1_underrun_cnt", unr_cnt - u0, 0);
    check("s1_idle_miso_oe", miso_oe, 0);
    check("s1_idle_miso", miso, 0);

    // Back-to-back bytes in one frame
    load(8'hAA);
    r0 = rxv_cnt; u0 = unr_cnt;
    frame_start();
    load(8'h55);
    check("s2_tx_ready_full", tx_ready, 0);
    spi_bits(8'hCC, 8, mi);
    check("s2_miso_byte0", mi, 8'hAA);
    check("s2_rx_byte0", rx_seen, 8'hCC);
    spi_bits(8'h33, 8, mi);
    check("s2_miso_byte1", mi, 8'h55);
    check("s2_rx_byte1", rx_seen, 8'h33);
    frame_end();
    check("s2_rx_valid_cnt", rxv_cnt - r0, 2);
    check("s2_underrun_cnt", unr_cnt - u0, 0);
    check("s2_tx_ready", tx_ready, 1);

    // Frame with an empty buffer
    u0 = unr_cnt;
    frame_start();
    check("s3_underrun_at_start", unr_cnt - u0, 1);
    spi_bits(8'h96, 8, mi);
    check("s3_miso_zero", mi, 8'h00);
    frame_end();
    check("s3_underrun_cnt", unr_cnt - u0, 1);
    check("s3_rx_data", rx_data, 8'h96);

    // Deselect mid-byte, then a clean frame
    r0 = rxv_cnt;
    frame_start();
    spi_bits(8'hF0, 5, mi);
    frame_end();
    check("s4_no_rx_valid", rxv_cnt - r0, 0);
    check("s4_rx_data_held", rx_data, 8'h96);
    check("s4_busy", busy, 0);
    frame_start();
    spi_bits(8'h5E, 8, mi);
    frame_end();
    check("s4_rx_after_abort", rx_data, 8'h5E);
    check("s4_rx_valid_cnt", rxv_cnt - r0, 1);

    // tx_load while full is ignored
    load(8'h5A);
    load(8'hFF);
    check("s5_tx_ready_full", tx_ready, 0);
    frame_start();
    spi_bits(8'hC3, 8, mi);
    check("s5_miso_orig", mi, 8'h5A);
    frame_end();
    check("s5_rx_data", rx_data, 8'hC3);

    // Reset mid-frame
    r0 = rxv_cnt;
    frame_start();
    load(8'h77);
    spi_bits(8'h81, 3, mi);
    check("s5_pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("s5_rst_miso", miso, 0);
    check("s5_rst_miso_oe", miso_oe, 0);
    check("s5_rst_tx_ready", tx_ready, 1);
    check("s5_rst_rx_valid", rx_valid, 0);
    check("s5_rst_underrun", tx_underrun, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_rx_data", rx_data, 8'h00);
    clks(2);
    rst_n = 1'b1;
    clks(20);
    check("s5_no_restart_busy", busy, 0);
    check("s5_no_rx_valid", rxv_cnt - r0, 0);
    cs_n = 1'b1;
    sclk = 1'b0;
    clks(HALF);

    // sclk activity while deselected
    r0 = rxv_cnt;
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      clks(HALF);
    end
    check("s6_no_rx_valid", rxv_cnt - r0, 0);
    check("s6_miso_oe", miso_oe, 0);
    check("s6_busy", busy, 0);
    load(8'h3C);
    frame_start();
    spi_bits(8'hE7, 8, mi);
    check("s6_miso_bits", mi, 8'h3C);
    frame_end();
    check("s6_rx_data", rx_data, 8'hE7);
    check("s6_rx_valid_cnt", rxv_cnt - r0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter: DATA_W, 8, frame width in bits; only 8 is supported.
REQ-002 Parameter: SYNC_STAGES, 2, flops in each input synchroniser; minimum 2.
REQ-003 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 Port: sclk  in  1  SPI serial clock from the controller; asynchronous to clk; mode 0 (CPOL=0, CPHA=0).
REQ-006 Port: cs_n  in  1  SPI chip select; active-low; asynchronous to clk.
REQ-007 Port: mosi  in  1  serial data from the controller; MSB first.
REQ-008 Port: miso  out  1  serial data to the controller; MSB first.
REQ-009 Port: miso_oe  out  1  output enable for miso; 1 only while the frame is active.
REQ-010 Port: tx_data  in  8  byte to transmit.
REQ-011 Port: tx_load  in  1  writes tx_data into the transmit buffer when tx_ready=1.
REQ-012 Port: tx_ready  out  1  transmit buffer is empty.
REQ-013 Port: rx_data  out  8  last complete received byte; held until the next byte completes.
REQ-014 Port: rx_valid  out  1  one-clk pulse; a new rx_data value is present.
REQ-015 Port: tx_underrun  out  1  one-clk pulse; a byte started with an empty buffer.
REQ-016 Port: busy  out  1  FSM is in state ACTIVE.

Function
REQ-017 The block shall pass sclk, cs_n and mosi each through a SYNC_STAGES flop synchroniser; all logic shall use only the synchronised versions (s_sclk, s_cs_n, s_mosi).
- Synchroniser reset values: sclk=0, cs_n=1, mosi=0.
REQ-018 Edge detection shall compare each synchronised signal with a registered copy of it.
- Rise: current=1 and previous=0.
- Fall: current=0 and previous=1.
REQ-019 The FSM shall have two states, IDLE and ACTIVE.
- IDLE->ACTIVE on an s_cs_n fall.
- ACTIVE->IDLE on an s_cs_n rise.
- No other transitions.
REQ-020 On IDLE->ACTIVE (frame start):
- Bit counter shall clear to 0.
- The transmit buffer shall move into the tx shift register, and miso shall equal its MSB on the following clk.
REQ-021 In ACTIVE, on each s_sclk rise:
- s_mosi shall shift into the LSB of the rx shift register.
- The 3-bit bit counter shall increment, wrapping 7->0.
REQ-022 In ACTIVE, on each s_sclk fall, the tx shift register shall shift left, and miso shall present the next bit.
- Exception: after the 8th rise of a byte, the transmit buffer shall be reloaded instead (back-to-back bytes in one frame).
REQ-023 On the s_sclk rise that samples bit 8 (counter=7):
- rx_data shall take the full byte on that same clk edge.
- rx_valid shall be 1 for exactly the next clk cycle.
REQ-024 Transfer and the tx_ready flag:
- Each transfer from the buffer (frame start or reload) shall set tx_ready=1.
- tx_load with tx_ready=1 shall store tx_data and clear tx_ready on the next clk edge.
- tx_load with tx_ready=0 shall be ignored.
REQ-025 When a transfer finds the buffer empty:
- The tx shift register shall load 0x00.
- tx_underrun shall pulse for one clk.
- A tx_load in that same cycle shall be stored for the next byte.
REQ-026 If s_cs_n rises mid-byte (counter≠0):
- The partial rx byte shall be discarded with no rx_valid.
- rx_data shall be unchanged, and the counter shall clear.
REQ-027 miso_oe shall be 1 in ACTIVE and 0 in IDLE; miso shall be 0 whenever miso_oe=0.
- In IDLE, s_sclk and s_mosi edges shall have no effect.
REQ-028 Timing guarantee, valid when sclk high and low phases are each ≥ SYNC_STAGES+2 clk periods:
- rx_valid shall assert within SYNC_STAGES+2 clk cycles of the raw 8th sclk rise.

Reset
REQ-029 While rst_n=0 the block shall be held in reset, independent of clk.
- FSM=IDLE; counter=0; shift registers=0x00.
- rx_data=0x00; transmit buffer empty.
- miso=0, miso_oe=0, tx_ready=1, rx_valid=0, tx_underrun=0, busy=0.
REQ-030 Reset asserted mid-frame shall abort the frame with no rx_valid.
- After rst_n rises, no frame shall start until the next cs_n fall.

Verification
REQ-031 The bench shall cover these scenarios:
- Load 0xA5; frame of one byte with mosi=0x3C. Expected: miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; no tx_underrun.
- Load 0xAA, then load 0x55 during the first byte; 16-bit frame with mosi 0xCC,0x33. Expected: miso 0xAA then 0x55; rx_valid twice with 0xCC then 0x33.
- Frame with no tx_load. Expected: miso=0x00 for the whole byte; tx_underrun pulses once at frame start.
- cs_n raised after 5 sclk rises. Expected: no rx_valid; rx_data unchanged; busy=0; the next full frame receives correctly.
- tx_load while tx_ready=0. Expected: ignored, and the original byte is transmitted; rst_n pulsed mid-frame gives every output its reset value.
- sclk toggled while cs_n=1. Expected: no rx_valid, miso_oe=0, counter unchanged.
